base2_log: RTL and testbench

- Integer floor(log2) unit for the MFCC mel stage. Converts an unsigned accumulated filter-bank energy into its most-significant-set-bit index.
- The mel block scales that index into a log energy.
- Provides a zero-latency combinational result for in-state use by the mel FSM.
- Also provides a one-cycle registered copy with a valid strobe for pipelined consumers.

---
 rtl/base2_log_pkg.sv | 16 +
 rtl/base2_log.sv | 80 ++++++++
 tb/tb_base2_log.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/base2_log_pkg.sv
// Shared MFCC constants: default filter-bank energy width and the helper that
// derives the width of a floor(log2) result from an operand width.
package base2_log_pkg;

    localparam int ENERGY_W = 32;

    // Number of bits needed to hold a bit index 0..w-1 (at least 1).
    function automatic int log_width(input int w);
        if (w < 2) begin
            return 1;
        end else begin
            return $clog2(w);
        end
    endfunction

endpackage

// File: rtl/base2_log.sv
// Integer floor(log2) of an unsigned energy word: combinational result for the
// mel FSM plus a one-cycle registered copy qualified by valid_i.
module base2_log
    import base2_log_pkg::*;
#(
    parameter int WIDTH = ENERGY_W,
    parameter int LOG_W = log_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] number_i,
    input  logic             valid_i,
    output logic [LOG_W-1:0] log_o,
    output logic             zero_o,
    output logic [LOG_W-1:0] log_q,
    output logic             zero_q,
    output logic             valid_o
);

    // Binary search over halves: each level decides one result bit, MSB first,
    // and narrows the window to the half that holds the leading one.
    function automatic logic [LOG_W-1:0] msb_index(input logic [WIDTH-1:0] value);
        logic [WIDTH-1:0] window;
        logic [LOG_W-1:0] idx;
        window = value;
        idx    = '0;
        for (int s = LOG_W - 1; s >= 0; s--) begin
            if ((window >> (1 << s)) != '0) begin
                idx[s] = 1'b1;
                window = window >> (1 << s);
            end else begin
                idx[s] = 1'b0;
            end
        end
        return idx;
    endfunction

    logic [LOG_W-1:0] log_s;
    logic             zero_s;
    logic [LOG_W-1:0] log_d;
    logic             zero_d;
    logic             valid_d;

    // Combinational encoder; independent of clock and reset.
    always_comb begin
        log_s  = msb_index(number_i);
        zero_s = (number_i == '0);
    end

    assign log_o  = log_s;
    assign zero_o = zero_s;

    // Next state of the registered path: capture on valid, hold otherwise.
    always_comb begin
        log_d   = log_q;
        zero_d  = zero_q;
        valid_d = valid_i;
        if (valid_i) begin
            log_d  = log_s;
            zero_d = zero_s;
        end else begin
            log_d  = log_q;
            zero_d = zero_q;
        end
    end

    // Output registers; reset value describes an empty (zero) operand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            log_q   <= '0;
            zero_q  <= 1'b1;
            valid_o <= 1'b0;
        end else begin
            log_q   <= log_d;
            zero_q  <= zero_d;
            valid_o <= valid_d;
        end
    end

endmodule

// File: tb/tb_base2_log.sv
// Self-checking bench for base2_log: directed corner cases plus randomized
// operands compared against an arithmetic floor(log2) reference.
module tb_base2_log;

    logic        clk;
    logic        rst_n;
    logic [31:0] number_i;
    logic        valid_i;
    logic [4:0]  log_o;
    logic        zero_o;
    logic [4:0]  log_q;
    logic        zero_q;
    logic        valid_o;

    int n_tests;
    int n_fail;

    // Reference state of the registered path.
    int m_log;
    int m_zero;
    int m_valid;

    base2_log #(.WIDTH(32), .LOG_W(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .number_i (number_i),
        .valid_i  (valid_i),
        .log_o    (log_o),
        .zero_o   (zero_o),
        .log_q    (log_q),
        .zero_q   (zero_q),
        .valid_o  (valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // floor(log2(x)) by repeated halving; 0 for x == 0.
    function automatic int ref_log(input logic [31:0] x);
        longint unsigned v;
        int n;
        v = x;
        n = 0;
        while (v > 1) begin
            v = v / 2;
            n++;
        end
        return n;
    endfunction

    task automatic apply(input logic [31:0] x, input logic v);
        number_i = x;
        valid_i  = v;
        #1;
    endtask

    task automatic check_comb(input string tag);
        check_eq({tag, ".log_o"},  32'(log_o),  32'(ref_log(number_i)));
        check_eq({tag, ".zero_o"}, 32'(zero_o), (number_i == 32'd0) ? 32'd1 : 32'd0);
    endtask

    // Clock edge plus reference update for the registered path.
    task automatic tick();
        @(posedge clk);
        m_valid = int'(valid_i);
        if (valid_i) begin
            m_log  = ref_log(number_i);
            m_zero = (number_i == 32'd0) ? 1 : 0;
        end
        #1;
    endtask

    task automatic check_reg(input string tag);
        check_eq({tag, ".log_q"},   32'(log_q),   32'(m_log));
        check_eq({tag, ".zero_q"},  32'(zero_q),  32'(m_zero));
        check_eq({tag, ".valid_o"}, 32'(valid_o), 32'(m_valid));
    endtask

    task automatic model_reset();
        m_log   = 0;
        m_zero  = 1;
        m_valid = 0;
    endtask

    initial begin
        logic [31:0] x;
        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b1;
        number_i = 32'd0;
        valid_i  = 1'b0;
        model_reset();

        // Reset: registered outputs cleared, combinational path live.
        #2 rst_n = 1'b0;
        apply(32'h40, 1'b0);
        check_eq("rst_comb.log_o", 32'(log_o), 32'd6);
        check_reg("rst_held");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_reg("rst_released");

        // Walking one and low-bit fill.
        for (int n = 0; n < 32; n++) begin
            apply(32'd1 << n, 1'b0);
            check_eq("walk.log_o", 32'(log_o), 32'(n));
            check_eq("walk.zero_o", 32'(zero_o), 32'd0);
        end
        apply(32'h1FF, 1'b0);        check_comb("fill_1ff");
        check_eq("fill_1ff.exact", 32'(log_o), 32'd8);

        // Zero and extremes.
        apply(32'h0, 1'b0);          check_comb("zero");
        check_eq("zero.exact", 32'(zero_o), 32'd1);
        apply(32'h1, 1'b0);          check_comb("one");
        apply(32'hFFFF_FFFF, 1'b0);  check_eq("all_ones", 32'(log_o), 32'd31);
        apply(32'h8000_0000, 1'b0);  check_eq("msb_only", 32'(log_o), 32'd31);
        apply(32'h7FFF_FFFF, 1'b0);  check_eq("below_msb", 32'(log_o), 32'd30);

        // Back-to-back pipeline, then gaps that must hold.
        apply(32'h10, 1'b1); tick(); check_eq("pipe0.log_q", 32'(log_q), 32'd4); check_reg("pipe0");
        apply(32'h3, 1'b1);  tick(); check_eq("pipe1.log_q", 32'(log_q), 32'd1); check_reg("pipe1");
        apply(32'h0, 1'b1);  tick(); check_eq("pipe2.zero_q", 32'(zero_q), 32'd1); check_reg("pipe2");
        apply(32'hFF, 1'b0); tick(); check_reg("gap0");
        apply(32'hF0F0, 1'b0); tick(); check_eq("gap1.log_q", 32'(log_q), 32'd0); check_reg("gap1");

        // Asynchronous reset between valid samples.
        apply(32'h100, 1'b1); tick(); check_reg("pre_rst");
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_reg("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        apply(32'h400, 1'b1); tick();
        check_eq("resume.log_q", 32'(log_q), 32'd10);
        check_reg("resume");

        // Randomized operands spread across all magnitudes.
        for (int i = 0; i < 10000; i++) begin
            x = $urandom;
            x = x >> $urandom_range(0, 32);
            apply(x, ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
            check_comb("rand");
            tick();
            check_reg("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
